dm_cache_ctrl: RTL

- Parametrised direct-mapped cache controller between the core's load/store port and a line-wide backing memory.
- Adds real tags, per-line valid bits and an automatic refill FSM with a request/acknowledge memory handshake.
- Writes are write-through, no-write-allocate.
- Adds a flush input and saturating hit/miss counters. The address is a word address.

---
 rtl/dm_cache_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate cache controller with a
// line-refill FSM, a flush input and saturating hit/miss statistics.
module dm_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    hit,
  input  logic                    flush,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W*WORDS-1:0] mem_rdata,
  input  logic                    mem_ack,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, TAG, REFILL, WRMEM, RESP} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] data_mem  [LINES][WORDS];
  logic [TAG_W-1:0]  tag_store [LINES];
  logic [LINES-1:0]  valid;

  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              hit_l;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              lookup_hit;
  logic [DATA_W-1:0] refill_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign off        = addr_l[OFF_W-1:0];
  assign idx        = addr_l[OFF_W+IDX_W-1:OFF_W];
  assign tag        = addr_l[ADDR_W-1:OFF_W+IDX_W];
  assign lookup_hit = valid[idx] && (tag_store[idx] == tag);

  always_comb begin
    refill_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (off == k[OFF_W-1:0]) refill_word = mem_rdata[DATA_W*k +: DATA_W];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!flush && cpu_req) state_next = TAG;
      TAG: begin
        if (we_l)            state_next = WRMEM;
        else if (lookup_hit) state_next = RESP;
        else                 state_next = REFILL;
      end
      REFILL:  if (mem_ack) state_next = RESP;
      WRMEM:   if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Control and registered outputs; everything here is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      cpu_ready <= 1'b0;
      hit       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: if (flush) valid <= '0;
        TAG: begin
          if (lookup_hit) hit_cnt  <= sat_inc(hit_cnt);
          else            miss_cnt <= sat_inc(miss_cnt);
          if (we_l) begin
            mem_addr  <= addr_l;
            mem_wdata <= wdata_l;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
          end else if (lookup_hit) begin
            cpu_rdata <= data_mem[idx][off];
            hit       <= 1'b1;
            cpu_ready <= 1'b1;
          end else begin
            mem_addr  <= {addr_l[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_we    <= 1'b0;
            mem_req   <= 1'b1;
          end
        end
        REFILL: if (mem_ack) begin
          valid[idx] <= 1'b1;
          cpu_rdata  <= refill_word;
          mem_req    <= 1'b0;
          hit        <= 1'b0;
          cpu_ready  <= 1'b1;
        end
        WRMEM: if (mem_ack) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          hit       <= hit_l;
          cpu_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request latch and cache arrays carry no reset; valid bits guard the arrays.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (!flush && cpu_req) begin
        we_l    <= cpu_we;
        addr_l  <= cpu_addr;
        wdata_l <= cpu_wdata;
      end
      TAG: begin
        hit_l <= lookup_hit;
        if (we_l && lookup_hit) data_mem[idx][off] <= wdata_l;
      end
      REFILL: if (mem_ack) begin
        for (int k = 0; k < WORDS; k++) data_mem[idx][k] <= mem_rdata[DATA_W*k +: DATA_W];
        tag_store[idx] <= tag;
      end
      default: ;
    endcase
  end

endmodule
